polytone: RTL

Multi-channel square-wave tone generator with per-channel note duration and a delta-sigma mixed speaker output. It is the successor to the single-channel speaker tone generator. The CPU core drives its configuration port from the shared write-data register plus a channel select. The single `speaker` output goes to the speaker pin, and the per-channel `active`/`done` status lets programs sequence notes without busy-wait delay loops.

---
 rtl/polytone.sv | 128 ++++++++++++
 1 files changed

// File: rtl/polytone.sv
// polytone: multi-channel square-wave tone generator. Each channel owns a
// half-period divider and an optional toggle-count duration. The channel
// squares are mixed into one speaker bit by a first-order delta-sigma
// accumulator, so the density of ones on the output equals sum/CHANNELS.
module polytone #(
    parameter int CHANNELS  = 4,
    parameter int DIV_WIDTH = 32,
    parameter int DUR_WIDTH = 24,
    parameter int CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 cfg_we,
    input  logic [CW-1:0]        cfg_chan,
    input  logic [DIV_WIDTH-1:0] cfg_divider,
    input  logic [DUR_WIDTH-1:0] cfg_duration,
    input  logic                 mute,
    output logic                 speaker,
    output logic [CHANNELS-1:0]  active,
    output logic [CHANNELS-1:0]  done
);
    // Popcount width holds 0..CHANNELS; the accumulator needs one more bit
    // because acc+sum reaches 2*CHANNELS-1 before the wrap subtraction.
    localparam int SW  = $clog2(CHANNELS + 1);
    localparam int AW  = SW + 1;
    localparam int CWP = CW + 1;
    localparam logic [AW-1:0]  CH_A = AW'(CHANNELS);
    localparam logic [CWP-1:0] CH_C = CWP'(CHANNELS);

    logic [CHANNELS-1:0] sq_vec;
    logic                chan_ok;
    logic [SW-1:0]       sum_next;
    logic [AW-1:0]       t_next;
    logic [AW-1:0]       acc_reg;
    logic [AW-1:0]       acc_next;
    logic                spk_reg;
    logic                spk_next;

    // Selects at or above CHANNELS (possible when CHANNELS is not a power
    // of two) must not touch any channel.
    assign chan_ok = ({1'b0, cfg_chan} < CH_C);

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        logic [DIV_WIDTH-1:0] div_reg;
        logic [DIV_WIDTH-1:0] phase_reg;
        logic [DUR_WIDTH-1:0] rem_reg;
        logic                 sq_reg;
        logic                 done_reg;
        logic                 wr;

        assign wr = cfg_we && chan_ok && (cfg_chan == CW'(gi));

        // Channel divider/duration/square state; a write overrides any
        // toggle or expiry happening on the same edge.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                div_reg   <= '0;
                phase_reg <= '0;
                rem_reg   <= '0;
                sq_reg    <= 1'b0;
                done_reg  <= 1'b0;
            end else begin
                done_reg <= 1'b0;
                if (wr) begin
                    div_reg   <= cfg_divider;
                    rem_reg   <= cfg_duration;
                    phase_reg <= '0;
                    sq_reg    <= 1'b0;
                end else if (div_reg == '0) begin
                    phase_reg <= '0;
                    sq_reg    <= 1'b0;
                end else if (phase_reg != div_reg) begin
                    phase_reg <= phase_reg + DIV_WIDTH'(1);
                end else begin
                    phase_reg <= '0;
                    if (rem_reg == DUR_WIDTH'(1)) begin
                        // Last toggle: stop the channel and force the square
                        // low, which truncates the high half for odd counts.
                        rem_reg  <= '0;
                        div_reg  <= '0;
                        sq_reg   <= 1'b0;
                        done_reg <= 1'b1;
                    end else begin
                        sq_reg <= ~sq_reg;
                        if (rem_reg != '0) begin
                            rem_reg <= rem_reg - DUR_WIDTH'(1);
                        end
                    end
                end
            end
        end

        assign sq_vec[gi] = sq_reg;
        assign active[gi] = (div_reg != '0);
        assign done[gi]   = done_reg;
    end

    // Count how many channel squares are currently high and form the
    // next delta-sigma accumulator value.
    always_comb begin
        sum_next = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            sum_next = sum_next + SW'(sq_vec[i]);
        end
        t_next = acc_reg + AW'(sum_next);
        if (t_next >= CH_A) begin
            spk_next = 1'b1;
            acc_next = t_next - CH_A;
        end else begin
            spk_next = 1'b0;
            acc_next = t_next;
        end
    end

    // Registered mixer; mute only gates the output, never the accumulator.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc_reg <= '0;
            spk_reg <= 1'b0;
        end else begin
            acc_reg <= acc_next;
            spk_reg <= spk_next;
        end
    end

    assign speaker = spk_reg & ~mute;

endmodule
